axis_pkt_tx: RTL

AXIS_PKT_TX -- requirements
Module: axis_pkt_tx

---
 rtl/axis_pkt_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/axis_pkt_tx.sv
// axis_pkt_tx: 16x16 payload FIFO feeding an AXI-Stream style packet
// transmitter. A command gives the beat count and the number of valid bits
// in the final beat. The transmitter pops one FIFO word per beat, masks the
// tail of the last beat and pulses tx_done once the final beat is accepted.
module axis_pkt_tx #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              wr_full,
    output logic [4:0]        fifo_level,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_len,
    input  logic [4:0]        cmd_tail,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic [7:0]        m_keep,
    input  logic              m_ready,
    output logic              tx_done
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t state_q, state_d;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] fifo_mem [16];
    logic [3:0]        wr_ptr_q, wr_ptr_d;
    logic [3:0]        rd_ptr_q, rd_ptr_d;
    logic [4:0]        level_q, level_d;
    logic              fifo_full, fifo_empty, push, pop;

    // Packet context latched at command acceptance
    logic [7:0]        len_q, len_d;
    logic [4:0]        tail_q, tail_d;
    logic [8:0]        beat_q, beat_d;

    // Output stage
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [7:0]        m_keep_q, m_keep_d;
    logic              tx_done_q, tx_done_d;

    // Holds cmd_ready low for the cycle following a reset edge
    logic              rst_seen_q, rst_seen_d;

    logic              cmd_fire, load, beat_fire, beats_left, final_beat;

    // Tail values of 0 or above the word width mean a full final beat.
    function automatic logic [4:0] eff_tail(input logic [4:0] tail);
        return ((tail == 5'd0) || (int'(tail) > DATA_W)) ? 5'(DATA_W) : tail;
    endfunction

    // Clear every bit at or above the tail position.
    function automatic logic [DATA_W-1:0] tail_mask(input logic [DATA_W-1:0] word,
                                                    input logic [4:0]        tail);
        logic [DATA_W-1:0] mask;
        if (int'(tail) >= DATA_W) mask = '1;
        else                      mask = (DATA_W'(1) << tail) - DATA_W'(1);
        return word & mask;
    endfunction

    assign fifo_full  = (level_q == 5'd16);
    assign fifo_empty = (level_q == 5'd0);
    assign wr_full    = fifo_full;
    assign fifo_level = level_q;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign m_keep     = m_keep_q;
    assign tx_done    = tx_done_q;

    assign beat_fire  = m_valid_q && m_ready;
    assign cmd_fire   = cmd_valid && cmd_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: a command starts a packet, acceptance of the last beat ends it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_fire) state_d = SEND;
            SEND:    if (beat_fire && m_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: command handshake and the beat-load strobe
    always_comb begin
        cmd_ready  = (state_q == IDLE) && !rst_seen_q;
        beats_left = (beat_q <= {1'b0, len_q});
        final_beat = (beat_q == {1'b0, len_q});
        load       = (state_q == SEND) && !fifo_empty && beats_left &&
                     (!m_valid_q || m_ready);
    end

    // FIFO pointer/level update; a pop frees a slot for a same-cycle write
    always_comb begin
        pop      = load;
        push     = wr_en && !rst && (!fifo_full || pop);
        wr_ptr_d = push ? wr_ptr_q + 4'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 4'd1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage write (data only, no reset)
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= wr_data;
    end

    // Packet context and output beat construction
    always_comb begin
        len_d      = len_q;
        tail_d     = tail_q;
        beat_d     = beat_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_keep_d   = m_keep_q;
        tx_done_d  = 1'b0;
        rst_seen_d = rst;

        if (cmd_fire) begin
            len_d  = cmd_len;
            tail_d = eff_tail(cmd_tail);
            beat_d = 9'd0;
        end

        if (load) begin
            m_valid_d = 1'b1;
            beat_d    = beat_q + 9'd1;
            if (final_beat) begin
                m_data_d = tail_mask(fifo_mem[rd_ptr_q], tail_q);
                m_keep_d = {3'b000, tail_q};
                m_last_d = 1'b1;
            end else begin
                m_data_d = fifo_mem[rd_ptr_q];
                m_keep_d = 8'd16;
                m_last_d = 1'b0;
            end
        end else if (beat_fire) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            tx_done_d = m_last_q;
        end
    end

    // Register bank; reset clears FIFO, outputs and packet context
    always_ff @(posedge clk) begin
        rst_seen_q <= rst_seen_d;
        if (rst) begin
            wr_ptr_q  <= 4'd0;
            rd_ptr_q  <= 4'd0;
            level_q   <= 5'd0;
            len_q     <= 8'd0;
            tail_q    <= 5'd0;
            beat_q    <= 9'd0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_keep_q  <= 8'd0;
            tx_done_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            len_q     <= len_d;
            tail_q    <= tail_d;
            beat_q    <= beat_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_keep_q  <= m_keep_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule
